// File: rtl/sprite_engine_pkg.sv
// Shared constants and types for the sprite renderer.
package sprite_pkg;

  // Per-sprite register offsets
  localparam logic [3:0] REG_X     = 4'd0;
  localparam logic [3:0] REG_Y     = 4'd1;
  localparam logic [3:0] REG_COLOR = 4'd2;
  localparam logic [3:0] REG_CTRL  = 4'd3;
  localparam logic [3:0] REG_BMAP0 = 4'd4;

  // CTRL register bit positions
  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_FLIPX = 1;
  localparam int unsigned CTRL_FLIPY = 2;

  // Colour constants {R8,G8,B8}
  localparam logic [23:0] BLACK  = 24'h000000;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;
  localparam logic [23:0] INDIGO = 24'h4B0082;

  // Colour and control attributes, shadowed and committed as one unit
  typedef struct packed {
    logic [23:0] color;
    logic        flip_y;
    logic        flip_x;
    logic        enable;
  } spr_attr_t;

endpackage

// File: rtl/sprite_engine_if.sv
// Register write port shared by all sprite units.
interface sprite_engine_if #(
  parameter int unsigned SEL_W = 2
);
  logic             wrEn;
  logic [SEL_W-1:0] wrSel;
  logic [3:0]       wrReg;
  logic [31:0]      wrData;

  modport master (output wrEn, wrSel, wrReg, wrData);
  modport slave  (input  wrEn, wrSel, wrReg, wrData);
endinterface

// File: rtl/sprite_engine_unit.sv
// One sprite: shadow/live registers, bitmap, stage-1 window test, stage-2 opacity.
module sprite_unit
  import sprite_pkg::*;
#(
  parameter int unsigned IDX    = 0,
  parameter int unsigned SPR_W  = 8,
  parameter int unsigned SPR_H  = 8,
  parameter int unsigned HPOS_W = 12,
  parameter int unsigned VPOS_W = 11,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     commit,
  input  logic signed [HPOS_W-1:0] h_pix,
  input  logic signed [VPOS_W-1:0] v_pix,
  input  logic                     wr_en,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic [3:0]               wr_reg,
  input  logic [31:0]              wr_data,
  output logic [23:0]              color,
  output logic                     opaque_c
);

  localparam int unsigned HX = HPOS_W + 1;
  localparam int unsigned VX = VPOS_W + 1;
  localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  logic signed [HPOS_W-1:0] sh_x, lv_x;
  logic signed [VPOS_W-1:0] sh_y, lv_y;
  spr_attr_t                sh_attr, lv_attr;
  logic [SPR_W-1:0]         bmap [SPR_H];

  logic                 sel_c, is_bmap_c;
  logic [4:0]           row_off_c;
  logic signed [HX-1:0] col_c;
  logic signed [VX-1:0] row_c;
  logic                 hit_c;
  logic                 hit_q;
  logic [CW-1:0]        col_q, bit_idx_c;
  logic [RW-1:0]        row_q, eff_row_c;
  logic                 unused_bits;

  // Write decode; offsets past the last bitmap row fall through untouched
  always_comb begin
    sel_c     = wr_en && (wr_sel == SEL_W'(IDX));
    row_off_c = {1'b0, wr_reg} - {1'b0, REG_BMAP0};
    is_bmap_c = (wr_reg >= REG_BMAP0) && (row_off_c < 5'(SPR_H));
  end

  // Shadow registers take writes at any time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_x    <= '0;
      sh_y    <= '0;
      sh_attr <= '0;
    end else if (sel_c) begin
      case (wr_reg)
        REG_X:     sh_x          <= wr_data[HPOS_W-1:0];
        REG_Y:     sh_y          <= wr_data[VPOS_W-1:0];
        REG_COLOR: sh_attr.color <= wr_data[23:0];
        REG_CTRL: begin
          sh_attr.enable <= wr_data[CTRL_EN];
          sh_attr.flip_x <= wr_data[CTRL_FLIPX];
          sh_attr.flip_y <= wr_data[CTRL_FLIPY];
        end
        default: ;
      endcase
    end
  end

  // Live registers follow the shadows only at the vSync commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lv_x    <= '0;
      lv_y    <= '0;
      lv_attr <= '0;
    end else if (commit) begin
      lv_x    <= sh_x;
      lv_y    <= sh_y;
      lv_attr <= sh_attr;
    end
  end

  // Bitmap rows are written straight through, no shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(SPR_H); r++) bmap[r] <= '0;
    end else if (sel_c && is_bmap_c) begin
      bmap[row_off_c[RW-1:0]] <= wr_data[SPR_W-1:0];
    end
  end

  // Stage 1: offset into the sprite window at one extra bit so nothing wraps
  always_comb begin
    col_c = $signed({h_pix[HPOS_W-1], h_pix}) - $signed({lv_x[HPOS_W-1], lv_x});
    row_c = $signed({v_pix[VPOS_W-1], v_pix}) - $signed({lv_y[VPOS_W-1], lv_y});
    hit_c = lv_attr.enable &&
            !col_c[HX-1] && ($unsigned(col_c) < HX'(SPR_W)) &&
            !row_c[VX-1] && ($unsigned(row_c) < VX'(SPR_H));
  end

  // Stage-1 pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      hit_q <= hit_c;
      col_q <= col_c[CW-1:0];
      row_q <= row_c[RW-1:0];
    end
  end

  // Stage 2: flip and bitmap lookup; MSB of a row is the leftmost pixel
  always_comb begin
    eff_row_c = lv_attr.flip_y ? (RW'(SPR_H - 1) - row_q) : row_q;
    bit_idx_c = lv_attr.flip_x ? col_q : (CW'(SPR_W - 1) - col_q);
    opaque_c  = hit_q && bmap[eff_row_c][bit_idx_c];
  end

  assign color       = lv_attr.color;
  assign unused_bits = ^{wr_data, col_c, row_c};

endmodule

// File: rtl/sprite_engine.sv
// Multi-sprite renderer: priority mux, collision accumulator, vSync commit, active delay.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPR_W       = 8,
  parameter int unsigned SPR_H       = 8,
  parameter int unsigned HPOS_W      = 12,
  parameter int unsigned VPOS_W      = 11,
  parameter int unsigned SEL_W       = 2
) (
  input  logic                     pixelClock,
  input  logic                     resetN,
  input  logic signed [HPOS_W-1:0] horizontalPix,
  input  logic signed [VPOS_W-1:0] verticalPix,
  input  logic                     inActiveDisplay,
  input  logic                     vSync,
  input  logic [23:0]              bgColor,
  sprite_engine_if.slave           wr,
  output logic [23:0]              pixelOut,
  output logic                     activeOut,
  output logic [NUM_SPRITES-1:0]   collision
);

  logic                   vsync_q;
  logic                   commit_c;
  logic                   active_d1;
  logic [NUM_SPRITES-1:0] opaque_c;
  logic [23:0]            spr_color [NUM_SPRITES];
  logic [23:0]            pix_c;
  logic                   coll_now_c;
  logic [NUM_SPRITES-1:0] acc;

  assign commit_c = vSync && !vsync_q;

  // Sprite units
  for (genvar gi = 0; gi < int'(NUM_SPRITES); gi++) begin : g_spr
    sprite_unit #(
      .IDX    (gi),
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .HPOS_W (HPOS_W),
      .VPOS_W (VPOS_W),
      .SEL_W  (SEL_W)
    ) u_spr (
      .clk      (pixelClock),
      .rst_n    (resetN),
      .commit   (commit_c),
      .h_pix    (horizontalPix),
      .v_pix    (verticalPix),
      .wr_en    (wr.wrEn),
      .wr_sel   (wr.wrSel),
      .wr_reg   (wr.wrReg),
      .wr_data  (wr.wrData),
      .color    (spr_color[gi]),
      .opaque_c (opaque_c[gi])
    );
  end

  // vSync edge history and first active-flag delay
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      vsync_q   <= 1'b0;
      active_d1 <= 1'b0;
    end else begin
      vsync_q   <= vSync;
      active_d1 <= inActiveDisplay;
    end
  end

  // Lowest index wins; two or more opaque sprites on an active pixel is a collision
  always_comb begin
    pix_c = bgColor;
    for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
      if (opaque_c[i]) pix_c = spr_color[i];
    end
    coll_now_c = active_d1 && ($countones(opaque_c) > 1);
  end

  // Registered pixel, blanked outside active video
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      pixelOut  <= BLACK;
      activeOut <= 1'b0;
    end else begin
      pixelOut  <= active_d1 ? pix_c : BLACK;
      activeOut <= active_d1;
    end
  end

  // Frame collision accumulator; a hit on the commit cycle seeds the new frame
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      acc       <= '0;
      collision <= '0;
    end else if (commit_c) begin
      collision <= acc;
      acc       <= coll_now_c ? opaque_c : '0;
    end else if (coll_now_c) begin
      acc <= acc | opaque_c;
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Directed + randomized bench for sprite_engine against a pixel-level reference model.
module tb_sprite_engine;
  import sprite_pkg::*;

  localparam int NS = 4;
  localparam logic [23:0] RED = 24'hFF0000;

  logic               pixelClock = 1'b0;
  logic               resetN;
  logic signed [11:0] hpix;
  logic signed [10:0] vpix;
  logic               act, vs;
  logic [23:0]        bgc;
  logic [23:0]        pixelOut;
  logic               activeOut;
  logic [3:0]         collision;

  sprite_engine_if #(.SEL_W(2)) wif ();

  sprite_engine #(
    .NUM_SPRITES(4), .SPR_W(8), .SPR_H(8), .HPOS_W(12), .VPOS_W(11), .SEL_W(2)
  ) dut (
    .pixelClock      (pixelClock),
    .resetN          (resetN),
    .horizontalPix   (hpix),
    .verticalPix     (vpix),
    .inActiveDisplay (act),
    .vSync           (vs),
    .bgColor         (bgc),
    .wr              (wif),
    .pixelOut        (pixelOut),
    .activeOut       (activeOut),
    .collision       (collision)
  );

  always #5 pixelClock = ~pixelClock;

  // Reference model state
  int          sh_x [NS], sh_y [NS], lv_x [NS], lv_y [NS];
  logic [23:0] sh_c [NS], lv_c [NS];
  logic [2:0]  sh_k [NS], lv_k [NS];
  logic [7:0]  bm   [NS][8];
  logic [3:0]  acc_m, coll_m;
  logic        vs_prev;
  logic [23:0] exp_q [$];
  logic        act_q [$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; lv_x[i] = 0; lv_y[i] = 0;
      sh_c[i] = '0; lv_c[i] = '0; sh_k[i] = '0; lv_k[i] = '0;
      for (int r = 0; r < 8; r++) bm[i][r] = '0;
    end
    acc_m = '0; coll_m = '0; vs_prev = 1'b0;
    exp_q.delete(); act_q.delete();
  endtask

  // Screen pixel as seen by the viewer: top-most opaque sprite colour, else background
  function automatic logic [23:0] model_pix(input int h, input int v, output logic [3:0] o);
    logic [23:0] res;
    int c, rw, lc;
    res = bgc;
    o = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      c = h - lv_x[i];
      rw = v - lv_y[i];
      if (lv_k[i][0] && c >= 0 && c < 8 && rw >= 0 && rw < 8) begin
        if (lv_k[i][2]) rw = 7 - rw;
        lc = lv_k[i][1] ? 7 - c : c;   // bitmap column counted from the left
        if (bm[i][rw][7 - lc]) begin
          o[i] = 1'b1;
          res = lv_c[i];
        end
      end
    end
    return res;
  endfunction

  // One pixel clock: drive, advance model, compare the pixel presented two cycles earlier
  task automatic cyc(input int h, input int v, input logic a);
    logic [23:0] e, eo;
    logic [3:0] o;
    logic ao;
    int sel, rg;
    logic signed [11:0] tx;
    logic signed [10:0] ty;
    hpix = 12'(h); vpix = 11'(v); act = a;
    e = model_pix(h, v, o);
    if (!a) e = '0;
    if (a && $countones(o) >= 2) acc_m = acc_m | o;
    if (vs && !vs_prev) begin
      for (int i = 0; i < NS; i++) begin
        lv_x[i] = sh_x[i]; lv_y[i] = sh_y[i]; lv_c[i] = sh_c[i]; lv_k[i] = sh_k[i];
      end
      coll_m = acc_m;
      acc_m = '0;
    end
    vs_prev = vs;
    if (wif.wrEn) begin
      sel = int'(wif.wrSel);
      rg = int'(wif.wrReg);
      tx = wif.wrData[11:0];
      ty = wif.wrData[10:0];
      if (sel < NS) begin
        if (rg == 0) sh_x[sel] = tx;
        else if (rg == 1) sh_y[sel] = ty;
        else if (rg == 2) sh_c[sel] = wif.wrData[23:0];
        else if (rg == 3) sh_k[sel] = wif.wrData[2:0];
        else if (rg >= 4 && rg < 12) bm[sel][rg - 4] = wif.wrData[7:0];
      end
    end
    exp_q.push_back(e);
    act_q.push_back(a);
    @(posedge pixelClock); #1;
    if (exp_q.size() >= 2) begin
      eo = exp_q.pop_front();
      ao = act_q.pop_front();
      chk($sformatf("pixelOut(h=%0d,v=%0d)", h, v), 32'(pixelOut), 32'(eo));
      chk("activeOut", 32'(activeOut), 32'(ao));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1'b0);
  endtask

  task automatic wr(input int sel, input int rg, input logic [31:0] d);
    wif.wrEn = 1'b1; wif.wrSel = 2'(sel); wif.wrReg = 4'(rg); wif.wrData = d;
    cyc(0, 0, 1'b0);
    wif.wrEn = 1'b0;
  endtask

  // vSync pulse, optionally with a register write on the commit cycle
  task automatic vsync(input logic do_wr, input int sel, input int rg, input logic [31:0] d);
    idle(2);
    vs = 1'b1;
    if (do_wr) begin
      wif.wrEn = 1'b1; wif.wrSel = 2'(sel); wif.wrReg = 4'(rg); wif.wrData = d;
    end
    cyc(0, 0, 1'b0);
    wif.wrEn = 1'b0;
    chk("collision", 32'(collision), 32'(coll_m));
    cyc(0, 0, 1'b0);
    vs = 1'b0;
    idle(2);
  endtask

  int h, v, s;
  logic [31:0] rnd;

  initial begin
    resetN = 1'b0; hpix = '0; vpix = '0; act = 1'b0; vs = 1'b0; bgc = 24'h102030;
    wif.wrEn = 1'b0; wif.wrSel = '0; wif.wrReg = '0; wif.wrData = '0;
    model_reset();
    repeat (3) @(posedge pixelClock);
    #1;
    chk("reset pixelOut", 32'(pixelOut), 32'h0);
    chk("reset activeOut", 32'(activeOut), 32'h0);
    chk("reset collision", 32'(collision), 32'h0);
    resetN = 1'b1;
    idle(2);

    // Basic placement and bitmap MSB-left
    wr(0, 0, 10); wr(0, 1, 5); wr(0, 2, 32'(INDIGO)); wr(0, 3, 1); wr(0, 4, 32'h81);
    vsync(1'b0, 0, 0, 0);
    cyc(10, 5, 1); cyc(11, 5, 1); cyc(17, 5, 1); cyc(18, 5, 1); cyc(10, 6, 1);
    idle(2);

    // Shadowing: mid-frame X write, then X write on the commit cycle
    wr(0, 0, 100);
    cyc(100, 5, 1); cyc(10, 5, 1);
    vsync(1'b0, 0, 0, 0);
    cyc(100, 5, 1); cyc(10, 5, 1);
    vsync(1'b1, 0, 0, 30);
    cyc(100, 5, 1); cyc(30, 5, 1);
    vsync(1'b0, 0, 0, 0);
    cyc(30, 5, 1); cyc(100, 5, 1);

    // Left clipping and flipX
    wr(0, 0, -3); wr(0, 4, 32'hFF);
    vsync(1'b0, 0, 0, 0);
    for (int c = -1; c <= 6; c++) cyc(c, 5, 1);
    wr(0, 0, 0); wr(0, 3, 3); wr(0, 4, 32'hC0);
    vsync(1'b0, 0, 0, 0);
    for (int c = 0; c <= 8; c++) cyc(c, 5, 1);

    // Priority and collision
    wr(0, 0, 20); wr(0, 1, 20); wr(0, 2, 32'(RED)); wr(0, 3, 1);
    wr(2, 0, 18); wr(2, 1, 18); wr(2, 2, 32'(WHITE)); wr(2, 3, 1);
    for (int r = 0; r < 8; r++) begin
      wr(0, 4 + r, 32'hFF);
      wr(2, 4 + r, 32'hFF);
    end
    vsync(1'b0, 0, 0, 0);
    cyc(20, 20, 1); cyc(19, 19, 1); cyc(30, 20, 1);
    vsync(1'b0, 0, 0, 0);
    chk("collision overlap", 32'(collision), 32'h5);
    cyc(19, 19, 1); cyc(27, 27, 1);
    vsync(1'b0, 0, 0, 0);
    chk("collision cleared", 32'(collision), 32'h0);

    // Blanking over an opaque pixel
    cyc(20, 20, 0); cyc(20, 20, 1); cyc(21, 21, 0); cyc(21, 21, 1);

    // Asynchronous mid-line reset
    cyc(20, 20, 1); cyc(20, 20, 1);
    #2 resetN = 1'b0;
    #1;
    chk("async reset pixelOut", 32'(pixelOut), 32'h0);
    chk("async reset activeOut", 32'(activeOut), 32'h0);
    chk("async reset collision", 32'(collision), 32'h0);
    model_reset();
    act = 1'b0;
    @(posedge pixelClock); #1;
    resetN = 1'b1;
    cyc(20, 20, 1); cyc(0, 0, 1); cyc(21, 21, 1);
    vsync(1'b0, 0, 0, 0);
    cyc(20, 20, 1); cyc(0, 0, 1);
    wr(0, 0, 20); wr(0, 1, 20); wr(0, 2, 32'(RED)); wr(0, 3, 1); wr(0, 4, 32'hFF);
    cyc(20, 20, 1);
    vsync(1'b0, 0, 0, 0);
    cyc(20, 20, 1); cyc(27, 20, 1); cyc(20, 21, 1);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NS; i++) begin
        wr(i, 0, 32'(int'($urandom_range(0, 100)) - 10));
        wr(i, 1, 32'(int'($urandom_range(0, 60)) - 10));
        wr(i, 2, $urandom);
        rnd = $urandom;
        wr(i, 3, {29'd0, rnd[2:1], (rnd[4:3] != 2'b00)});
        for (int r = 0; r < 8; r++) wr(i, 4 + r, $urandom);
      end
      if (f == 0) wr(3, 0, 2044);
      wr(1, 12, 32'hFFFF_FFFF);
      wr(2, 15, 32'hFFFF_FFFF);
      vsync(1'b0, 0, 0, 0);
      for (int k = 0; k < 150; k++) begin
        s = int'($urandom_range(0, NS - 1));
        h = lv_x[s] + int'($urandom_range(0, 11)) - 2;
        v = lv_y[s] + int'($urandom_range(0, 11)) - 2;
        if (f == 0 && k < 8) h = -2048 + k;
        h = int'($signed(12'(h)));
        v = int'($signed(11'(v)));
        cyc(h, v, ($urandom_range(0, 9) != 0));
      end
      vsync(1'b0, 0, 0, 0);
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_engine.md
Name: sprite_engine

Overview:
- Parametrised multi-sprite renderer between the HDMI timing source (hdmi_tx counters) and the pixel RGB inputs.
- Replaces the single hard-coded 8x8 sprite with:
  - NUM_SPRITES independent monochrome sprites, each with its own position, colour and flip controls;
  - fixed priority, where the lowest index is on top;
  - per-frame collision detection;
  - a register write port whose position, colour and control values are committed only at vertical sync, so sprites never tear.

Parameters:
- NUM_SPRITES, 4, number of sprite units (1..16).
- SPR_W, 8, sprite width in pixels (1..32).
- SPR_H, 8, sprite height in rows (1..12).
- HPOS_W, 12, width of the signed horizontal coordinate.
- VPOS_W, 11, width of the signed vertical coordinate.
- SEL_W, 2, sprite select width; must be at least clog2(NUM_SPRITES).

Ports:
- pixelClock  in  1  pixel clock.
- resetN  in  1  asynchronous, active-low reset.
- horizontalPix  in  HPOS_W  signed current column, 2 cycles ahead of display.
- verticalPix  in  VPOS_W  signed current row.
- inActiveDisplay  in  1  active-video qualifier, aligned with the coordinates.
- vSync  in  1  vertical sync, active high.
- bgColor  in  24  background {R8,G8,B8}.
- wrEn  in  1  register write strobe, single cycle.
- wrSel  in  SEL_W  target sprite.
- wrReg  in  4  register offset within the sprite.
- wrData  in  32  write data; fields are taken from the LSBs.
- pixelOut  out  24  registered RGB.
- activeOut  out  1  inActiveDisplay delayed 2 cycles.
- collision  out  NUM_SPRITES  per-sprite collision flags from the previous frame.

Behaviour:
- Reset (asynchronous, on resetN low):
  - pixelOut = 0, activeOut = 0, collision = 0.
  - All shadow and live registers = 0: sprites disabled, x = y = 0, colour 0.
  - All bitmap rows = 0.
- Register map, per sprite:
  - 0 = X, signed HPOS_W.
  - 1 = Y, signed VPOS_W.
  - 2 = COLOR, 24-bit.
  - 3 = CTRL: bit0 enable, bit1 flipX, bit2 flipY.
  - 4..4+SPR_H-1 = bitmap row r, SPR_W bits; the MSB is the leftmost pixel.
- Write rules:
  - Offsets at or beyond 4+SPR_H, and wrSel >= NUM_SPRITES, are ignored.
  - X, Y, COLOR and CTRL writes go to shadow registers.
  - Bitmap writes take effect immediately and are not shadowed.
- Commit:
  - On the first cycle vSync is seen high (rising edge, registered), every shadow register copies to its live register.
  - A write in that same cycle lands in shadow and commits at the next frame.
- Pipeline, latency 2:
  - Stage 1, per sprite:
    - col = horizontalPix − X, computed at HPOS_W+1 bits signed.
    - row = verticalPix − Y, computed at VPOS_W+1 bits signed.
    - hit = enable && 0 ≤ col < SPR_W && 0 ≤ row < SPR_H.
    - Register hit, col and row.
    - Negative X/Y, where the sprite is partly off-screen at top or left, must clip correctly.
  - Stage 2:
    - Effective row = flipY ? SPR_H−1−row : row.
    - Bit index = flipX ? col : SPR_W−1−col.
    - opaque_i = hit_i && bitmap bit.
    - pixelOut = COLOR of the lowest-index opaque sprite, else bgColor.
    - If the delayed active flag is 0, pixelOut = 0.
- Collision:
  - Accumulator acc[i] |= opaque_i whenever two or more sprites are opaque on the same active pixel.
  - On the vSync rising edge: collision <= acc; acc <= 0.
  - A collision that occurs on the commit cycle itself goes to the new acc.
- Coordinates outside the sprite window never hit, including wrap-around of large positive X; no modulo behaviour.
- A mid-frame reset clears everything immediately; output is black until the data is rewritten.

Decomposition:
- Package sprite_pkg holds:
  - register offsets REG_X, REG_Y, REG_COLOR, REG_CTRL, REG_BMAP0;
  - CTRL bit positions;
  - colour constants BLACK, WHITE, INDIGO.
- Sub-module sprite_unit, instantiated NUM_SPRITES times by generate. It holds:
  - the shadow and live registers;
  - the bitmap;
  - stage-1 hit/col/row and stage-2 opaque bit.
- The top level keeps the priority mux, the collision accumulator, vSync edge detection and the active-flag delay.

Test Plan:
1. Sprite 0 set to X=10, Y=5, colour 0x4B0082, enable=1, row0=8'b1000_0001, then vSync pulse. Present (10,5) → pixelOut 0x4B0082 two cycles later; (11,5) → bgColor; (17,5) → 0x4B0082.
2. Shadowing: write X=100 mid-frame → rendering still uses the old X until the next vSync edge; afterwards a hit occurs at column 100. Also write X on the exact commit cycle → takes effect one frame later.
3. Clipping: X=−3, row0=8'hFF → columns 0..4 opaque and column 5 background. flipX with row0=8'b1100_0000 and X=0 → opaque at columns 6 and 7 only.
4. Priority and collision: sprites 0 (red) and 2 (white) overlap at (20,20) → pixelOut red; after the next vSync, collision = 4'b0101. A frame with no overlap → collision returns to 0 after the following vSync.
5. Blanking: inActiveDisplay=0 over an opaque pixel → pixelOut 0 and activeOut 0 with 2-cycle alignment.
6. Reset: assert resetN low mid-line with sprites active → outputs 0 immediately, asynchronously. After release, registers read back disabled and no hit occurs until the sprite is rewritten and a vSync commit follows.
